// File: rtl/score_disp_drv.sv
// Four-digit multiplexed seven-segment driver for the game score/status outputs.
// Frame-consistent snapshot, leading-zero blanking, level dp, game-over blink and best-score hold.
module score_disp_drv #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [3:0] num3_disp,
    input  logic [3:0] num2_disp,
    input  logic [3:0] num1_disp,
    input  logic [3:0] num0_disp,
    input  logic [2:0] game_state,
    input  logic [1:0] level,
    input  logic       show_best,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic               sb_meta_reg, sb_sync_reg;
    logic [SCAN_W-1:0]  scan_cnt_reg;
    logic [1:0]         idx_reg;
    logic [15:0]        snap_reg, best_reg;
    logic               blink_ph_reg;
    logic [BLINK_W-1:0] blink_cnt_reg;
    logic [1:0]         prev_gs_reg;
    logic [3:0]         an_reg;
    logic [6:0]         seg_reg;
    logic               dp_reg;

    logic [1:0]  gs;
    logic [15:0] live_score, snap_src;
    logic        go_edge, scan_wrap, frame_wrap, blink_wrap, dp_next;
    logic [6:0]  digit_seg [4];
    logic        unused_gs2;

    assign gs         = game_state[1:0];
    assign unused_gs2 = game_state[2];
    assign live_score = {num3_disp, num2_disp, num1_disp, num0_disp};
    assign go_edge    = (gs == 2'b10) && (prev_gs_reg != 2'b10);
    assign scan_wrap  = (scan_cnt_reg == SCAN_W'(SCAN_DIV - 1));
    assign frame_wrap = scan_wrap && (idx_reg == 2'd3);
    assign blink_wrap = (blink_cnt_reg == BLINK_W'(BLINK_DIV - 1));
    assign snap_src   = (sb_sync_reg || gs == 2'b00) ? best_reg : live_score;
    assign dp_next    = !(((gs == 2'b01) || (gs == 2'b11)) && (idx_reg == level));

    // A digit is a leading zero when it and every more significant digit are zero.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            logic lead_zero;
            if (gi == 0) begin : g_lsd
                assign lead_zero = 1'b0;
            end else begin : g_upper
                assign lead_zero = (snap_reg[15:4*gi] == '0);
            end
            assign digit_seg[gi] = lead_zero ? 7'h7F : bcd_to_seg(snap_reg[4*gi +: 4]);
        end
    endgenerate

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sb_meta_reg   <= 1'b0;
            sb_sync_reg   <= 1'b0;
            scan_cnt_reg  <= '0;
            idx_reg       <= 2'd0;
            snap_reg      <= 16'h0000;
            best_reg      <= 16'h0000;
            blink_ph_reg  <= 1'b0;
            blink_cnt_reg <= '0;
            prev_gs_reg   <= 2'b00;
            an_reg        <= 4'b1111;
            seg_reg       <= 7'h7F;
            dp_reg        <= 1'b1;
        end else begin
            sb_meta_reg <= show_best;
            sb_sync_reg <= sb_meta_reg;
            prev_gs_reg <= gs;

            if (scan_wrap) begin
                scan_cnt_reg <= '0;
                idx_reg      <= idx_reg + 2'd1;
            end else begin
                scan_cnt_reg <= scan_cnt_reg + 1'b1;
            end

            // Snapshot samples the pre-update best, so a same-cycle game-over shows next frame.
            if (frame_wrap)
                snap_reg <= snap_src;
            if (go_edge && (live_score > best_reg))
                best_reg <= live_score;

            if (gs != 2'b10 || go_edge) begin
                blink_cnt_reg <= '0;
                blink_ph_reg  <= 1'b0;
            end else if (blink_wrap) begin
                blink_cnt_reg <= '0;
                blink_ph_reg  <= ~blink_ph_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end

            an_reg  <= blink_ph_reg ? 4'b1111 : ~(4'b0001 << idx_reg);
            seg_reg <= digit_seg[idx_reg];
            dp_reg  <= dp_next;
        end
    end

    assign an  = an_reg;
    assign seg = seg_reg;
    assign dp  = dp_reg;
endmodule
